// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: S-box, GF(2^8) xtime, rcon, round functions.
// Optional abort input enabled by AES_SEQ_ABORT_EN (see sequencer top).
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      4'd1:  c = 8'h01;
      4'd2:  c = 8'h02;
      4'd3:  c = 8'h04;
      4'd4:  c = 8'h08;
      4'd5:  c = 8'h10;
      4'd6:  c = 8'h20;
      4'd7:  c = 8'h40;
      4'd8:  c = 8'h80;
      4'd9:  c = 8'h1b;
      4'd10: c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte (row r, col c) lives at index 4c+r, MSB first.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++)
        a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4])
                             ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule: RotWord, SubWord, rcon, XOR chain.
// Purely combinational; used once per round by the sequencer.
module aes128_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rkey,
  input  logic [7:0]   rcon_b,
  output logic [127:0] rkey_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = rkey[127:96];
  assign w1 = rkey[95:64];
  assign w2 = rkey[63:32];
  assign w3 = rkey[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]),  sbox(rot[7:0])}
             ^ {rcon_b, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign rkey_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor, one round per clock, valid/ready in and out.
// Define AES_SEQ_ABORT_EN to add an abort input that drops the current block.
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter int ROUNDS    = 10,
  parameter bit CLEAR_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_SEQ_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] ct_out,
  output logic         busy
);

  if (ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes128_round_sequencer: ROUNDS must be 10");
  end

  seq_state_e   fsm;
  logic [3:0]   round;
  logic [127:0] state;
  logic [127:0] rkey;
  logic [127:0] rk_next;
  logic [127:0] sr;
  logic [127:0] nxt;
  logic         last;

  assign last = (round == 4'(ROUNDS));

  aes128_key_step u_key_step (
    .rkey      (rkey),
    .rcon_b    (rcon(round)),
    .rkey_next (rk_next)
  );

  // Final round skips MixColumns.
  assign sr  = shift_rows(sub_bytes(state));
  assign nxt = (last ? sr : mix_columns(sr)) ^ rk_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      round     <= '0;
      state     <= '0;
      rkey      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      ct_out    <= '0;
    end
`ifdef AES_SEQ_ABORT_EN
    else if (abort && fsm != IDLE) begin
      fsm       <= IDLE;
      round     <= '0;
      state     <= '0;
      rkey      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      if (CLEAR_OUT) ct_out <= '0;
    end
`endif
    else begin
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= pt_in ^ key_in;
            rkey     <= key_in;
            round    <= 4'd1;
            fsm      <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (round > 4'(ROUNDS)) begin
            fsm      <= IDLE;
            round    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state <= nxt;
            rkey  <= rk_next;
            if (last) begin
              fsm       <= DONE;
              round     <= '0;
              out_valid <= 1'b1;
              ct_out    <= nxt;
            end else begin
              round <= round + 4'd1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            if (CLEAR_OUT) ct_out <= '0;
          end
        end
        default: begin
          fsm       <= IDLE;
          round     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for aes128_round_sequencer.
// Reference AES is built from GF(2^8) inverse + affine map and word key expansion.
module tb_aes128_round_sequencer;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] pt_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] ct_out;
  logic         busy;
`ifdef AES_SEQ_ABORT_EN
  logic         abort = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] sb [256];

  aes128_round_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef AES_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .ct_out    (ct_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int b = 1; b < 256; b++)
      if (a != 8'h00 && gmul(a, 8'(b)) == 8'h01) v = 8'(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key,
                                           input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]}
            ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int i = 0; i < 16; i++) t[i] = s[4*(((i/4)+(i%4))%4) + i%4];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[4*c+q] = (rd == 10) ? t[4*c+q]
                   : gmul(t[4*c+q], 8'h02) ^ gmul(t[4*c+(q+1)%4], 8'h03)
                     ^ t[4*c+(q+2)%4] ^ t[4*c+(q+3)%4];
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*rd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] k);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    pt_in    = p;
    key_in   = k;
    tick();
    in_valid = 1'b0;
    pt_in    = rnd128();
    key_in   = rnd128();
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic consume(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ct_out !== '0) begin
      miscompares++;
      $display("FAIL %s_consume out_valid=%b in_ready=%b ct=%h required 0 1 0",
               nm, out_valid, in_ready, ct_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got=%b required 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid_busy got=%b%b required 00", out_valid, busy);
    end
    vectors++;
    if (ct_out !== '0) begin
      miscompares++;
      $display("FAIL reset_ct got=%h required 0", ct_out);
    end
  endtask

  task automatic test_fips(input string nm, input logic [127:0] k,
                           input logic [127:0] p, input logic [127:0] ct);
    int lat;
    send(p, k);
    wait_out(lat);
    vectors++;
    if (lat !== 10) begin
      miscompares++;
      $display("FAIL %s_latency got=%0d required 10", nm, lat);
    end
    vectors++;
    if (ct_out !== ct) begin
      miscompares++;
      $display("FAIL %s_ct got=%h required %h", nm, ct_out, ct);
    end
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_flags busy=%b in_ready=%b required 1 0",
               nm, busy, in_ready);
    end
    consume(nm);
  endtask

  task automatic test_random();
    logic [127:0] k, p, exp;
    int lat;
    for (int i = 0; i < 8; i++) begin
      k   = rnd128();
      p   = rnd128();
      exp = aes_ref(k, p);
      send(p, k);
      wait_out(lat);
      vectors++;
      if (ct_out !== exp || lat !== 10) begin
        miscompares++;
        $display("FAIL random_%0d ct=%h lat=%0d required %h lat 10",
                 i, ct_out, lat, exp);
      end
      consume("random");
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    send(C1_PT, C1_KEY);
    wait_out(lat);
    bad = 0;
    in_valid = 1'b1;
    pt_in    = B_PT;
    key_in   = B_KEY;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ct_out !== C1_CT || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL backpressure_hold bad_cycles=%0d required 0", bad);
    end
    consume("backpressure");
    tick();
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_no_accept busy=%b out_valid=%b required 0 0",
               busy, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got [$];
    int at [$];
    bit sent2;
    sent2 = 1'b0;
    out_ready = 1'b1;
    send(C1_PT, C1_KEY);
    for (int i = 0; i < 30; i++) begin
      if (out_valid) begin
        got.push_back(ct_out);
        at.push_back(cyc);
      end
      if (in_valid) begin
        in_valid = 1'b0;
        sent2 = 1'b1;
      end else if (in_ready && !sent2) begin
        in_valid = 1'b1;
        pt_in    = B_PT;
        key_in   = B_KEY;
      end
      tick();
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    vectors++;
    if (got.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d required 2", got.size());
    end else begin
      vectors++;
      if (got[0] !== C1_CT || got[1] !== B_CT) begin
        miscompares++;
        $display("FAIL b2b_order got=%h,%h required %h,%h",
                 got[0], got[1], C1_CT, B_CT);
      end
      vectors++;
      if (at[1] - at[0] != 12) begin
        miscompares++;
        $display("FAIL b2b_spacing got=%0d required 12", at[1] - at[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    send(B_PT, B_KEY);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0
        || ct_out !== '0) begin
      miscompares++;
      $display("FAIL midreset_state rdy=%b ov=%b busy=%b ct=%h required 1 0 0 0",
               in_ready, out_valid, busy, ct_out);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midreset_partial got=%0d required 0", bad);
    end
    test_fips("midreset_c1", C1_KEY, C1_PT, C1_CT);
  endtask

`ifdef AES_SEQ_ABORT_EN
  task automatic test_abort();
    int bad;
    int lat;
    send(C1_PT, C1_KEY);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_run busy=%b rdy=%b ov=%b required 0 1 0",
               busy, in_ready, out_valid);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL abort_run_output got=%0d required 0", bad);
    end
    send(B_PT, B_KEY);
    wait_out(lat);
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) bad++;
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (bad != 0 || ct_out !== '0) begin
      miscompares++;
      $display("FAIL abort_done ov_cycles=%0d ct=%h required 0 0", bad, ct_out);
    end
    abort = 1'b1;
    send(C1_PT, C1_KEY);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle_ignored busy=%b required 1", busy);
    end
    wait_out(lat);
    vectors++;
    if (ct_out !== C1_CT) begin
      miscompares++;
      $display("FAIL abort_idle_ct got=%h required %h", ct_out, C1_CT);
    end
    consume("abort_idle");
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    test_reset();
    test_fips("c1", C1_KEY, C1_PT, C1_CT);
    test_fips("b", B_KEY, B_PT, B_CT);
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_SEQ_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes128_round_sequencer.md
Name: aes128_round_sequencer

Overview:
- Iterative AES-128 encryption engine.
- Accepts one 128-bit plaintext block and one 128-bit key over a valid/ready handshake.
- Runs the initial AddRoundKey, then 10 rounds at one round per clock, and presents the ciphertext over a valid/ready output handshake.
- Owns the round counter, on-the-fly key schedule, and the control that skips the column mix in the final round.
- Sits between the block-level I/O wrapper and the combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey).

Parameters:
- ROUNDS, 10, number of cipher rounds. Only 10 is legal; elaboration error otherwise.
- CLEAR_OUT, 1, when 1, ct_out reads 0 whenever out_valid=0; when 0, ct_out holds the last value.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  pt_in/key_in valid
- in_ready  out  1  engine can accept a block
- pt_in  in  128  plaintext; byte 0 at [127:120]; column-major, column c = bits [127-32c -: 32]
- key_in  in  128  cipher key, same byte order
- out_valid  out  1  ct_out valid
- out_ready  in  1  consumer accepts ct_out
- ct_out  out  128  ciphertext, same byte order
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at an edge): FSM=IDLE, round=0, state=0, rkey=0. Outputs: in_ready=1, out_valid=0, ct_out=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state<=pt_in^key_in, rkey<=key_in, round<=1, go to RUN.
- RUN:
  - Each cycle: rkey_next = key_step(rkey, rcon[round]); state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rkey_next); rkey <= rkey_next.
  - MixColumns is bypassed when round==10.
  - round increments per cycle. When round==10, go to DONE (round<=0).
- DONE:
  - out_valid=1, ct_out=state, held stable until out_ready.
  - On out_ready: go to IDLE. in_ready rises the next cycle; no same-cycle bypass.
- Latency: handshake at edge E0, out_valid visible after edge E10. Throughput is one block per 12 cycles minimum (out_ready tied high).
- in_ready=0 in RUN and DONE. in_valid there is ignored, with no side effects.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed by round 1..10.
- GF(2^8) arithmetic: xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0). MixColumns matrix is [02 03 01 01] circulant, applied per 32-bit column.
- rst asserted mid-RUN or in DONE: abandons the block at the next edge and returns to reset values. No partial output.
- pt_in/key_in change after acceptance: no effect, since values are captured at handshake.
- round counter is 4 bits and never exceeds 10. Values 11-15 are unreachable and force IDLE if decoded.

Optional Feature:
- Macro: AES_SEQ_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 in RUN or DONE goes to IDLE at the next edge and clears state/rkey/round to 0. out_valid drops the next cycle.
  - abort has priority over out_ready in DONE.
  - abort in IDLE is ignored; in_valid in that cycle is still accepted.
- Undefined: no abort port; behaviour is exactly as above.

Decomposition:
- Package aes_pkg holds:
  - sbox function (256-entry case)
  - xtime function
  - rcon function (round -> byte)
  - FSM state enum typedef (IDLE/RUN/DONE)
  - localparam AES_ROUNDS=10
- Sub-module aes128_key_step: combinational RotWord/SubWord/rcon XOR chain producing the next 128-bit round key from rkey and rcon.
- Round datapath functions are called inline from the sequencer.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly after E10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> ct_out stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Back-to-back: two C.1/B blocks with out_ready=1 -> both correct, in order, 12 cycles apart.
- rst pulse at round 5 -> all outputs at reset values the next cycle. A new C.1 block then yields the correct ct.
- AES_SEQ_ABORT_EN: abort at round 3 -> IDLE, out_valid never asserts. abort in DONE with out_ready=1 -> out_valid drops, no duplicate output.
